pipe_exe_operand: RTL and testbench
===================================

// Module: pipe_exe_operand
// PURPOSE
//  ID/EXE pipeline register and EXE operand selection for the five-stage pipeline.
//  Captures decoded ID-stage controls and operands each cycle and detects load-use hazards.
//  Forwards from the MEM and WB stages, then drives the a/b/aluc inputs of the EXE ALU.
//  Also produces the forwarded store data and the control bits that travel on to the EX/MEM register.
// PARAMETERS
//  XLEN     32  datapath width
//  RA_IDX   31  link register written by jal
// PORTS
//  clock       in   1     rising-edge clock
//  resetn      in   1     asynchronous reset, active low
//  d_valid     in   1     ID holds a real instruction
//  d_wreg      in   1     ID instruction writes the register file
//  d_m2reg     in   1     ID instruction is a load
//  d_wmem      in   1     ID instruction is a store
//  d_aluc      in   4     ALU op code (package encoding)
//  d_aluimm    in   1     operand b = immediate
//  d_shift     in   1     operand a = shamt (imm[10:6])
//  d_jal       in   1     jal: ALU computes pc4+4, rn forced to RA_IDX
//  d_use_rs    in   1     ID instruction reads rs
//  d_use_rt    in   1     ID instruction reads rt
//  d_rs        in   5     rs index
//  d_rt        in   5     rt index
//  d_rn        in   5     destination index
//  d_qa        in   XLEN  regfile rs data
//  d_qb        in   XLEN  regfile rt data
//  d_imm       in   XLEN  extended immediate
//  d_pc4       in   XLEN  PC+4 of the ID instruction
//  flush       in   1     annul the ID instruction (taken control transfer)
//  m_wreg      in   1     MEM instruction writes a register
//  m_m2reg     in   1     MEM instruction is a load
//  m_rn        in   5     MEM destination index
//  m_alu       in   XLEN  MEM ALU result
//  m_mdata     in   XLEN  MEM load data (combinational read)
//  w_wreg      in   1     WB instruction writes a register
//  w_rn        in   5     WB destination index
//  w_data      in   XLEN  WB write-back data
//  stall       out  1     load-use stall; holds PC and the IF/ID register
//  e_valid     out  1     EXE holds a real instruction
//  e_wreg      out  1     registered d_wreg; 0 for a bubble
//  e_m2reg     out  1     registered d_m2reg
//  e_wmem      out  1     registered d_wmem; 0 for a bubble
//  e_rn        out  5     registered destination (RA_IDX when jal)
//  e_aluc      out  4     ALU op code
//  e_a         out  XLEN  ALU operand a
//  e_b         out  XLEN  ALU operand b
//  e_sdata     out  XLEN  forwarded rt value, used as store data
// BEHAVIOUR
//  - Reset (async, resetn=0): every EXE register is cleared to 0. Outputs e_valid/e_wreg/e_m2reg/e_wmem/e_rn/e_aluc are 0.
//  - Latency: ID values appear on the e_* outputs one clock after capture. e_a, e_b and e_sdata are combinational in the EXE cycle.
//  - stall = d_valid & e_valid & e_m2reg & (e_rn!=0) & ((d_use_rs & d_rs==e_rn) | (d_use_rt & d_rt==e_rn)). It is combinational.
//  - Bubble insert when stall | flush | ~d_valid: valid, wreg, m2reg, wmem, aluc and rn load 0; data fields are don't-care.
//    Stall and flush together also insert a bubble. Flush has no effect on the stall output.
//  - Otherwise all d_* fields load. For jal: rn=RA_IDX, aluc=ADD, a=pc4, b=4, so the result is PC+8.
//  - Forwarding runs per source (rs -> fa, rt -> fb) on the registered indices, in priority order:
//    1. index==0  -> register value, never forwarded.
//    2. m_wreg & m_rn==idx -> m_m2reg ? m_mdata : m_alu.
//    3. w_wreg & w_rn==idx -> w_data.
//    4. else the registered regfile value.
//  - e_a = jal ? pc4 : shift ? {27'b0, imm[10:6]} : fa.
//  - e_b = jal ? 4 : aluimm ? imm : fb. e_sdata = fb always.
//  - A load in MEM forwards m_mdata, so a load-use hazard costs exactly one bubble.
//  - Reset asserted mid-stall: all EXE registers clear, stall drops because e_valid=0, and the pipeline restarts clean.
// STRUCTURE
//  - Shared pipe_pkg: ALU opcode constants ADD=0000 SUB=0100 AND=0001 OR=0101 XOR=0010 LUI=0110 SLL=0011 SRL=0111 SRA=1111; RA_IDX; XLEN.
//  - Sub-module fwd_sel: index, regfile value, M/W sources -> forwarded value. It is instantiated twice, once for rs and once for rt.
// TESTING
//  1. Reset: hold resetn=0 with random d_* inputs -> every e_* output is 0 and stall=0. After release, the first valid ID instruction appears next cycle.
//  2. Forwarding: add r3 in MEM (m_alu=5), then sub reading r3 as rs -> e_a=5. With W also writing r3 (w_data=9), MEM wins -> e_a=5.
//  3. Load-use: lw r4 in EXE, then add reading r4 in ID -> stall=1 for one cycle and a bubble enters EXE (e_wreg=0).
//     Next cycle, with m_mdata=0x1234, the add sees e_a=0x1234.
//  4. r0: MEM writes r0 with m_alu=7 and EXE reads r0 -> e_a=0. An EXE load targeting r0 -> stall=0.
//  5. Control: jal with pc4=0x100 -> e_a=0x100, e_b=4, e_aluc=0000, e_rn=31.
//     sll with shamt=3 -> e_a=3. Flush together with stall -> bubble and e_wmem=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, link register, ALU op codes and
// the payload structs carried by the ID/EXE register.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned ALUC_W = 4;

  localparam logic [RIDX_W-1:0] RA_IDX = 5'd31;

  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SRA = 4'b1111;

  // Control half of the ID/EXE register; all-zero is a bubble.
  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALUC_W-1:0] aluc;
    logic [RIDX_W-1:0] rn;
    logic              aluimm;
    logic              shift;
    logic              jal;
  } ex_ctrl_t;

  // Data half of the ID/EXE register; meaningless while ctrl.valid is low.
  typedef struct packed {
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [XLEN-1:0]   qa;
    logic [XLEN-1:0]   qb;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc4;
  } ex_data_t;

endpackage

// File: rtl/pipe_exe_operand_fwd_sel.sv
// One forwarding mux for a single source register: MEM beats WB beats the
// regfile, and r0 is never forwarded.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [RIDX_W-1:0] idx_i,
  input  logic [XLEN-1:0]   rf_i,
  input  logic              m_wreg_i,
  input  logic              m_m2reg_i,
  input  logic [RIDX_W-1:0] m_rn_i,
  input  logic [XLEN-1:0]   m_alu_i,
  input  logic [XLEN-1:0]   m_mdata_i,
  input  logic              w_wreg_i,
  input  logic [RIDX_W-1:0] w_rn_i,
  input  logic [XLEN-1:0]   w_data_i,
  output logic [XLEN-1:0]   fwd_o
);

  always_comb begin
    fwd_o = rf_i;
    if (idx_i != '0) begin
      if (m_wreg_i && (m_rn_i == idx_i)) begin
        fwd_o = m_m2reg_i ? m_mdata_i : m_alu_i;
      end else if (w_wreg_i && (w_rn_i == idx_i)) begin
        fwd_o = w_data_i;
      end
    end
  end

endmodule

// File: rtl/pipe_exe_operand.sv
// ID/EXE pipeline register with load-use stall detection, MEM/WB forwarding
// and EXE ALU operand selection.
module pipe_exe_operand
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              d_valid,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic              d_wmem,
  input  logic [ALUC_W-1:0] d_aluc,
  input  logic              d_aluimm,
  input  logic              d_shift,
  input  logic              d_jal,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [RIDX_W-1:0] d_rs,
  input  logic [RIDX_W-1:0] d_rt,
  input  logic [RIDX_W-1:0] d_rn,
  input  logic [XLEN-1:0]   d_qa,
  input  logic [XLEN-1:0]   d_qb,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [XLEN-1:0]   d_pc4,
  input  logic              flush,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  input  logic [RIDX_W-1:0] m_rn,
  input  logic [XLEN-1:0]   m_alu,
  input  logic [XLEN-1:0]   m_mdata,
  input  logic              w_wreg,
  input  logic [RIDX_W-1:0] w_rn,
  input  logic [XLEN-1:0]   w_data,
  output logic              stall,
  output logic              e_valid,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic [RIDX_W-1:0] e_rn,
  output logic [ALUC_W-1:0] e_aluc,
  output logic [XLEN-1:0]   e_a,
  output logic [XLEN-1:0]   e_b,
  output logic [XLEN-1:0]   e_sdata
);

  ex_ctrl_t        ctrl_d, ctrl_q;
  ex_data_t        data_d, data_q;
  logic            bubble_c;
  logic [XLEN-1:0] fa_c, fb_c;

  // A load in EXE whose result the ID instruction needs cannot be forwarded yet.
  assign stall = d_valid & ctrl_q.valid & ctrl_q.m2reg & (ctrl_q.rn != '0) &
                 ((d_use_rs & (d_rs == ctrl_q.rn)) | (d_use_rt & (d_rt == ctrl_q.rn)));

  assign bubble_c = stall | flush | ~d_valid;

  always_comb begin
    ctrl_d = '0;
    data_d = '{rs: d_rs, rt: d_rt, qa: d_qa, qb: d_qb, imm: d_imm, pc4: d_pc4};
    if (!bubble_c) begin
      ctrl_d.valid  = 1'b1;
      ctrl_d.wreg   = d_wreg;
      ctrl_d.m2reg  = d_m2reg;
      ctrl_d.wmem   = d_wmem;
      ctrl_d.aluc   = d_jal ? ALU_ADD : d_aluc;
      ctrl_d.rn     = d_jal ? RA_IDX : d_rn;
      ctrl_d.aluimm = d_aluimm;
      ctrl_d.shift  = d_shift;
      ctrl_d.jal    = d_jal;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  fwd_sel u_fwd_rs (
    .idx_i     (data_q.rs),
    .rf_i      (data_q.qa),
    .m_wreg_i  (m_wreg),
    .m_m2reg_i (m_m2reg),
    .m_rn_i    (m_rn),
    .m_alu_i   (m_alu),
    .m_mdata_i (m_mdata),
    .w_wreg_i  (w_wreg),
    .w_rn_i    (w_rn),
    .w_data_i  (w_data),
    .fwd_o     (fa_c)
  );

  fwd_sel u_fwd_rt (
    .idx_i     (data_q.rt),
    .rf_i      (data_q.qb),
    .m_wreg_i  (m_wreg),
    .m_m2reg_i (m_m2reg),
    .m_rn_i    (m_rn),
    .m_alu_i   (m_alu),
    .m_mdata_i (m_mdata),
    .w_wreg_i  (w_wreg),
    .w_rn_i    (w_rn),
    .w_data_i  (w_data),
    .fwd_o     (fb_c)
  );

  assign e_valid = ctrl_q.valid;
  assign e_wreg  = ctrl_q.wreg;
  assign e_m2reg = ctrl_q.m2reg;
  assign e_wmem  = ctrl_q.wmem;
  assign e_rn    = ctrl_q.rn;
  assign e_aluc  = ctrl_q.aluc;

  // jal computes pc4 + 4 (the return address); shifts take shamt from imm[10:6].
  assign e_a = ctrl_q.jal   ? data_q.pc4 :
               ctrl_q.shift ? XLEN'(data_q.imm[10:6]) : fa_c;
  assign e_b = ctrl_q.jal    ? XLEN'(4) :
               ctrl_q.aluimm ? data_q.imm : fb_c;
  assign e_sdata = fb_c;

endmodule

// File: tb/tb_pipe_exe_operand.sv
// Directed bench for pipe_exe_operand: reset, forwarding, load-use stall,
// r0 handling, jal/shift operand selection, flush and reset during a stall.
module tb_pipe_exe_operand;
  import pipe_pkg::*;

  logic              clock = 1'b0;
  logic              resetn;
  logic              d_valid, d_wreg, d_m2reg, d_wmem;
  logic [3:0]        d_aluc;
  logic              d_aluimm, d_shift, d_jal, d_use_rs, d_use_rt;
  logic [4:0]        d_rs, d_rt, d_rn;
  logic [31:0]       d_qa, d_qb, d_imm, d_pc4;
  logic              flush;
  logic              m_wreg, m_m2reg;
  logic [4:0]        m_rn;
  logic [31:0]       m_alu, m_mdata;
  logic              w_wreg;
  logic [4:0]        w_rn;
  logic [31:0]       w_data;
  logic              stall, e_valid, e_wreg, e_m2reg, e_wmem;
  logic [4:0]        e_rn;
  logic [3:0]        e_aluc;
  logic [31:0]       e_a, e_b, e_sdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_exe_operand dut (
    .clock(clock), .resetn(resetn),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_pc4(d_pc4), .flush(flush),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu), .m_mdata(m_mdata),
    .w_wreg(w_wreg), .w_rn(w_rn), .w_data(w_data),
    .stall(stall), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
    .e_wmem(e_wmem), .e_rn(e_rn), .e_aluc(e_aluc), .e_a(e_a), .e_b(e_b),
    .e_sdata(e_sdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic id_nop();
    d_valid = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0; d_aluc = '0;
    d_aluimm = 0; d_shift = 0; d_jal = 0; d_use_rs = 0; d_use_rt = 0;
    d_rs = '0; d_rt = '0; d_rn = '0; d_qa = '0; d_qb = '0; d_imm = '0; d_pc4 = '0;
    flush = 0;
  endtask

  task automatic mw_idle();
    m_wreg = 0; m_m2reg = 0; m_rn = '0; m_alu = '0; m_mdata = '0;
    w_wreg = 0; w_rn = '0; w_data = '0;
  endtask

  // Register-register ALU instruction in ID.
  task automatic id_rr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rn, input logic [31:0] qa, input logic [31:0] qb);
    id_nop();
    d_valid = 1; d_wreg = 1; d_aluc = op; d_use_rs = 1; d_use_rt = 1;
    d_rs = rs; d_rt = rt; d_rn = rn; d_qa = qa; d_qb = qb;
  endtask

  // Load rn <- mem[rs + imm] in ID.
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rn, input logic [31:0] imm);
    id_nop();
    d_valid = 1; d_wreg = 1; d_m2reg = 1; d_aluc = ALU_ADD; d_aluimm = 1;
    d_use_rs = 1; d_rs = rs; d_rn = rn; d_imm = imm; d_qa = 32'h100;
  endtask

  initial begin
    resetn = 0;
    mw_idle();
    id_nop();
    // Reset with random ID inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      {d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal, d_use_rs, d_use_rt} = 8'($urandom);
      d_valid = 1; d_aluc = 4'($urandom); d_rs = 5'($urandom); d_rt = 5'($urandom);
      d_rn = 5'($urandom); d_qa = $urandom; d_qb = $urandom; d_imm = $urandom;
    end
    #1;
    chk("rst_valid", 32'(e_valid), 32'd0);
    chk("rst_wreg",  32'(e_wreg),  32'd0);
    chk("rst_m2reg", 32'(e_m2reg), 32'd0);
    chk("rst_wmem",  32'(e_wmem),  32'd0);
    chk("rst_rn",    32'(e_rn),    32'd0);
    chk("rst_aluc",  32'(e_aluc),  32'd0);
    chk("rst_stall", 32'(stall),   32'd0);

    // First instruction after release: add r5 = r1 + r2
    @(negedge clock);
    resetn = 1;
    id_rr(ALU_ADD, 5'd1, 5'd2, 5'd5, 32'd10, 32'd20);
    tick();
    chk("first_valid", 32'(e_valid), 32'd1);
    chk("first_wreg",  32'(e_wreg),  32'd1);
    chk("first_rn",    32'(e_rn),    32'd5);
    chk("first_a",     e_a,          32'd10);
    chk("first_b",     e_b,          32'd20);

    // Forwarding: sub r6 = r3 - r2
    id_rr(ALU_SUB, 5'd3, 5'd2, 5'd6, 32'hDEAD, 32'd1);
    tick();
    id_nop();
    chk("sub_aluc", 32'(e_aluc), 32'(ALU_SUB));
    m_wreg = 1; m_rn = 5'd3; m_alu = 32'd5; #1;
    chk("fwd_mem_a", e_a, 32'd5);
    w_wreg = 1; w_rn = 5'd3; w_data = 32'd9; #1;
    chk("fwd_mem_beats_wb", e_a, 32'd5);
    m_wreg = 0; #1;
    chk("fwd_wb_a", e_a, 32'd9);
    m_wreg = 1; m_m2reg = 1; m_rn = 5'd2; m_mdata = 32'h77; m_alu = 32'h55; #1;
    chk("fwd_load_b", e_b, 32'h77);
    chk("fwd_load_sdata", e_sdata, 32'h77);
    mw_idle(); #1;
    chk("no_fwd_a", e_a, 32'hDEAD);

    // Load-use: lw r4 in EXE, add r7 = r4 + r2 in ID
    id_lw(5'd1, 5'd4, 32'd8);
    tick();
    chk("lw_m2reg", 32'(e_m2reg), 32'd1);
    chk("lw_b_imm", e_b, 32'd8);
    id_rr(ALU_ADD, 5'd4, 5'd2, 5'd7, 32'hBAD, 32'd3);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_wreg",  32'(e_wreg),  32'd0);
    chk("lu_bubble_valid", 32'(e_valid), 32'd0);
    chk("lu_stall_drop",   32'(stall),   32'd0);
    tick();
    id_nop();
    m_wreg = 1; m_m2reg = 1; m_rn = 5'd4; m_mdata = 32'h1234; m_alu = 32'h108; #1;
    chk("lu_add_valid", 32'(e_valid), 32'd1);
    chk("lu_add_a", e_a, 32'h1234);
    chk("lu_add_rn", 32'(e_rn), 32'd7);
    mw_idle();

    // r0 is never forwarded and never causes a stall
    id_rr(ALU_ADD, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
    tick();
    m_wreg = 1; m_rn = 5'd0; m_alu = 32'd7; #1;
    chk("r0_no_fwd", e_a, 32'd0);
    mw_idle();
    id_lw(5'd1, 5'd0, 32'd4);
    tick();
    id_rr(ALU_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
    #1;
    chk("r0_no_stall", 32'(stall), 32'd0);

    // jal: a = pc4, b = 4, op forced ADD, rn forced 31
    id_nop();
    d_valid = 1; d_wreg = 1; d_jal = 1; d_aluc = ALU_SRA; d_rn = 5'd3; d_pc4 = 32'h100;
    d_qa = 32'h1111; d_qb = 32'h2222;
    tick();
    chk("jal_a",    e_a,          32'h100);
    chk("jal_b",    e_b,          32'd4);
    chk("jal_aluc", 32'(e_aluc),  32'd0);
    chk("jal_rn",   32'(e_rn),    32'd31);

    // sll r10 = r2 << 3
    id_nop();
    d_valid = 1; d_wreg = 1; d_shift = 1; d_aluc = ALU_SLL; d_use_rt = 1;
    d_rt = 5'd2; d_rn = 5'd10; d_qb = 32'h0F; d_imm = 32'h0000_00C0; d_qa = 32'hFFFF;
    tick();
    chk("sll_a",    e_a,         32'd3);
    chk("sll_b",    e_b,         32'h0F);
    chk("sll_aluc", 32'(e_aluc), 32'(ALU_SLL));

    // Flush together with stall: sw using r4 behind lw r4
    id_lw(5'd1, 5'd4, 32'd0);
    tick();
    id_nop();
    d_valid = 1; d_wmem = 1; d_use_rs = 1; d_use_rt = 1; d_rs = 5'd1; d_rt = 5'd4;
    d_aluimm = 1; flush = 1;
    #1;
    chk("flush_stall_out", 32'(stall), 32'd1);
    tick();
    chk("flush_wmem",  32'(e_wmem),  32'd0);
    chk("flush_valid", 32'(e_valid), 32'd0);
    // Flush alone annuls a valid store
    tick();
    chk("flush_only_wmem", 32'(e_wmem), 32'd0);
    flush = 0;
    tick();
    chk("store_wmem", 32'(e_wmem), 32'd1);

    // Reset during a stall
    id_lw(5'd1, 5'd4, 32'd0);
    tick();
    id_rr(ALU_ADD, 5'd2, 5'd4, 5'd11, 32'd1, 32'd2);
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    resetn = 0; #1;
    chk("mid_rst_stall", 32'(stall),   32'd0);
    chk("mid_rst_valid", 32'(e_valid), 32'd0);
    chk("mid_rst_m2reg", 32'(e_m2reg), 32'd0);
    @(negedge clock);
    resetn = 1;
    tick();
    chk("restart_valid", 32'(e_valid), 32'd1);
    chk("restart_rn",    32'(e_rn),    32'd11);
    chk("restart_b",     e_b,          32'd2);

    // ID not valid inserts a bubble
    id_nop();
    d_wreg = 1; d_rn = 5'd12;
    tick();
    chk("invalid_bubble_wreg", 32'(e_wreg), 32'd0);
    chk("invalid_bubble_rn",   32'(e_rn),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
